// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream, writes big-endian
// words to instruction memory, and releases the CPU once a checksum-verified frame is stored.
module program_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        start_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  dbg_state_o,
    output logic [15:0] dbg_index_o,
    output logic [7:0]  dbg_xor_o
);

    localparam logic [2:0] S_HDR0 = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [16:0] MEM_WORDS_L = 17'(MEM_WORDS);

    logic [2:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [7:0]  xor_q, xor_d;
    logic [23:0] shift_q, shift_d;
    logic [1:0]  byte_q, byte_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic [15:0] hdr_n;
    logic        last_word;

    // Handshake: a byte transfers on a rising edge where in_valid_i && in_ready_o;
    // in_ready_o depends only on state, never on in_valid_i.
    assign in_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
    assign accept     = in_valid_i && in_ready_o;

    // During HDR1, count_q[7:0] still holds N_hi captured in HDR0.
    assign hdr_n      = {count_q[7:0], in_data_i};
    assign last_word  = (index_q == (count_q - 16'd1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        xor_d   = xor_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    count_d = {8'h00, in_data_i};
                    xor_d   = xor_q ^ in_data_i;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    count_d = hdr_n;
                    xor_d   = xor_q ^ in_data_i;
                    if ({1'b0, hdr_n} > MEM_WORDS_L) begin
                        state_d = S_ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d   = xor_q ^ in_data_i;
                    shift_d = {shift_q[15:0], in_data_i};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + {14'd0, index_q, 2'b00};
                        wdata_d = {shift_q, in_data_i};
                        // Index stops at N-1 so it never passes MEM_WORDS-1.
                        if (last_word) begin
                            state_d = S_CHK;
                        end else begin
                            index_d = index_q + 16'd1;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_HDR0;
                    count_d = 16'd0;
                    index_d = 16'd0;
                    xor_d   = 8'd0;
                    byte_d  = 2'd0;
                end
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_HDR0;
            count_q <= 16'd0;
            index_q <= 16'd0;
            xor_q   <= 8'd0;
            shift_q <= 24'd0;
            byte_q  <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            xor_q   <= xor_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_hold_o   = (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);
    assign dbg_state_o  = state_q;
    assign dbg_index_o  = index_q;
    assign dbg_xor_o    = xor_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked every cycle,
// plus directed frames with hand-computed write lists and status levels.
module tb_program_loader;

    localparam int          MW   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;
    logic [15:0] dbg_index;
    logic [7:0]  dbg_xor;

    always #5 clk = ~clk;

    program_loader #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .start_i      (start),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .error_o      (error),
        .dbg_state_o  (dbg_state),
        .dbg_index_o  (dbg_index),
        .dbg_xor_o    (dbg_xor)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    // status: 0 loading, 1 done, 2 rejected
    int         m_status = 0;
    logic [7:0] m_bytes[$];
    logic       exp_ready = 1'b1;
    logic       exp_hold  = 1'b1;
    logic       exp_done  = 1'b0;
    logic       exp_err   = 1'b0;
    logic       exp_we    = 1'b0;
    logic [31:0] exp_addr  = 32'd0;
    logic [31:0] exp_data  = 32'd0;

    always @(posedge clk) begin
        int n;
        int nw;
        logic [7:0] x;
        exp_we = 1'b0;
        if (rst) begin
            m_status = 0;
            m_bytes.delete();
        end else if (m_status == 0) begin
            if (in_valid) begin
                m_bytes.push_back(in_data);
                n  = m_bytes.size();
                nw = (n >= 2) ? int'({m_bytes[0], m_bytes[1]}) : 0;
                if (n == 2) begin
                    if (nw > MW) m_status = 2;
                end else if (n > 2 && n <= 2 + 4 * nw) begin
                    if ((n - 2) % 4 == 0) begin
                        exp_we   = 1'b1;
                        exp_addr = BASE + 32'(4 * ((n - 2) / 4 - 1));
                        exp_data = {m_bytes[n-4], m_bytes[n-3], m_bytes[n-2], m_bytes[n-1]};
                    end
                end else if (n > 2) begin
                    x = 8'd0;
                    for (int i = 0; i < n - 1; i++) x = x ^ m_bytes[i];
                    m_status = (x == m_bytes[n-1]) ? 1 : 2;
                end
            end
        end else if (start) begin
            m_status = 0;
            m_bytes.delete();
        end
        exp_ready = (m_status == 0);
        exp_hold  = (m_status != 1);
        exp_done  = (m_status == 1);
        exp_err   = (m_status == 2);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
        check("done", 64'(done), 64'(exp_done));
        check("error", 64'(error), 64'(exp_err));
        check("imem_we", 64'(imem_we), 64'(exp_we));
        if (exp_we) begin
            check("imem_addr", 64'(imem_addr), 64'(exp_addr));
            check("imem_wdata", 64'(imem_wdata), 64'(exp_data));
        end
    end

    // ---------------- write scoreboard ----------------
    logic [63:0] wr_log[$];
    logic [63:0] exp_q[$];

    always @(posedge clk) begin
        if (imem_we === 1'b1) wr_log.push_back({imem_addr, imem_wdata});
    end

    task automatic check_writes(input string name);
        check({name, "_wr_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check({name, "_wr"}, wr_log[i], exp_q[i]);
        exp_q.delete();
        wr_log.delete();
    endtask

    // ---------------- driver tasks ----------------
    logic [7:0] frame_q[$];
    bit         rnd_start = 1'b0;

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = rnd_start && ($urandom_range(7, 0) == 0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = rnd_start && ($urandom_range(7, 0) == 0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], max_gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(3'd0));
        check("rst_addr", 64'(imem_addr), 64'(BASE));
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_index", 64'(dbg_index), 64'd0);
        check("rst_xor", 64'(dbg_xor), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        rst = 1'b0;
        idle(2);

        // N=1 back-to-back
        frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        send_frame(0);
        check("n1_done", 64'(done), 64'd1);
        check("n1_hold", 64'(cpu_hold), 64'd0);
        check("n1_ready", 64'(in_ready), 64'd0);
        check("n1_error", 64'(error), 64'd0);
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        idle(2);
        check_writes("n1");

        // start clears to HDR0; then N=0 frame
        pulse_start();
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_hold", 64'(cpu_hold), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check("start_index", 64'(dbg_index), 64'd0);
        check("start_xor", 64'(dbg_xor), 64'd0);
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("n0_done", 64'(done), 64'd1);
        check("n0_hold", 64'(cpu_hold), 64'd0);
        idle(2);
        check_writes("n0");

        // bad checksum, then recover
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hFF};
        send_frame(0);
        check("bad_error", 64'(error), 64'd1);
        check("bad_done", 64'(done), 64'd0);
        check("bad_hold", 64'(cpu_hold), 64'd1);
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        idle(2);
        check_writes("bad");
        pulse_start();
        check("recover_error", 64'(error), 64'd0);
        frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        send_frame(1);
        check("recover_done", 64'(done), 64'd1);
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        idle(2);
        check_writes("recover");

        // oversize headers: 257 and MEM_WORDS+1
        pulse_start();
        frame_q = '{8'h01, 8'h01};
        send_frame(0);
        check("n257_error", 64'(error), 64'd1);
        check("n257_ready", 64'(in_ready), 64'd0);
        send_byte(8'hA5, 0);
        idle(2);
        check_writes("n257");
        pulse_start();
        frame_q = '{8'h00, 8'h05};
        send_frame(0);
        check("n5_error", 64'(error), 64'd1);
        idle(2);
        check_writes("n5");

        // N = MEM_WORDS with gaps
        pulse_start();
        frame_q = '{8'h00, 8'h04,
                    8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                    8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44, 8'h04};
        send_frame(3);
        check("n4_done", 64'(done), 64'd1);
        exp_q.push_back({32'h0000_0000, 32'h1111_1111});
        exp_q.push_back({32'h0000_0004, 32'h2222_2222});
        exp_q.push_back({32'h0000_0008, 32'h3333_3333});
        exp_q.push_back({32'h0000_000C, 32'h4444_4444});
        idle(2);
        check_writes("n4");

        // reset while the 4th byte of word 0 is presented
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00};
        send_frame(0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h05;
        @(negedge clk);
        check("rst_mid_we", 64'(imem_we), 64'd0);
        check("rst_mid_index", 64'(dbg_index), 64'd0);
        check("rst_mid_xor", 64'(dbg_xor), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        idle(2);
        check_writes("rst_mid");
        frame_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_frame(0);
        check("fresh_done", 64'(done), 64'd1);
        exp_q.push_back({BASE, 32'hAABB_CCDD});
        idle(2);
        check_writes("fresh");

        // randomized frames
        rnd_start = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int         n;
            logic [7:0] x;
            logic [7:0] b;
            logic [31:0] w;
            pulse_start();
            n = int'($urandom_range(MW + 1, 0));
            frame_q.delete();
            frame_q.push_back(8'(n >> 8));
            frame_q.push_back(8'(n));
            x = frame_q[0] ^ frame_q[1];
            if (n <= MW) begin
                for (int k = 0; k < n; k++) begin
                    w = 32'd0;
                    for (int j = 0; j < 4; j++) begin
                        b = 8'($urandom);
                        frame_q.push_back(b);
                        x = x ^ b;
                        w = {w[23:0], b};
                    end
                    exp_q.push_back({BASE + 32'(4 * k), w});
                end
                if ($urandom_range(4, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
                frame_q.push_back(x);
            end
            send_frame(3);
            repeat (int'($urandom_range(3, 1))) begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            idle(2);
            check_writes("rnd");
        end
        rnd_start = 1'b0;

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
